// File: rtl/fft_input_loader.sv
// Serial-to-parallel loader for the 32-point DIT FFT: bit-reversed writes into a
// ping-pong frame buffer, full frames presented to the first butterfly stage.
module fft_input_loader #(
    parameter int N = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid_i,
    output logic            s_ready_o,
    input  logic [N-1:0]    s_r_i,
    input  logic [N-1:0]    s_i_i,
    input  logic            s_last_i,
    output logic            f_valid_o,
    input  logic            f_ready_i,
    output logic [32*N-1:0] f_r_o,
    output logic [32*N-1:0] f_i_o,
    output logic            frame_err_o
);

    logic [N-1:0] bankR_q [2][32];
    logic [N-1:0] bankI_q [2][32];
    logic [1:0]   full_q, full_d;
    logic         wrBank_q, wrBank_d;
    logic         rdBank_q, rdBank_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         frameErr_q, frameErr_d;
    logic         accept, consume, lastCnt;
    logic [4:0]   wrLane;

    function automatic logic [4:0] bitRev5(input logic [4:0] k);
        return {k[0], k[1], k[2], k[3], k[4]};
    endfunction

    assign s_ready_o   = !full_q[wrBank_q];
    assign f_valid_o   = full_q[rdBank_q];
    assign frame_err_o = frameErr_q;
    assign accept      = s_valid_i & s_ready_o;
    assign consume     = f_valid_o & f_ready_i;
    assign lastCnt     = (cnt_q == 5'd31);
    assign wrLane      = bitRev5(cnt_q);

    always_comb begin
        f_r_o = '0;
        f_i_o = '0;
        for (int j = 0; j < 32; j++) begin
            f_r_o[j*N +: N] = bankR_q[rdBank_q][j];
            f_i_o[j*N +: N] = bankI_q[rdBank_q][j];
        end
    end

    // Completion and consume always target different banks, so both updates can land together.
    always_comb begin
        full_d     = full_q;
        wrBank_d   = wrBank_q;
        rdBank_d   = rdBank_q;
        cnt_d      = cnt_q;
        frameErr_d = 1'b0;
        if (consume) begin
            full_d[rdBank_q] = 1'b0;
            rdBank_d         = !rdBank_q;
        end
        if (accept) begin
            frameErr_d = s_last_i ^ lastCnt;
            if (lastCnt) begin
                full_d[wrBank_q] = 1'b1;
                wrBank_d         = !wrBank_q;
                cnt_d            = 5'd0;
            end else if (s_last_i) begin
                cnt_d = 5'd0;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q     <= 2'b00;
            wrBank_q   <= 1'b0;
            rdBank_q   <= 1'b0;
            cnt_q      <= 5'd0;
            frameErr_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            wrBank_q   <= wrBank_d;
            rdBank_q   <= rdBank_d;
            cnt_q      <= cnt_d;
            frameErr_q <= frameErr_d;
        end
    end

    // Stale lanes from a discarded partial frame are overwritten before the bank is marked full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int j = 0; j < 32; j++) begin
                    bankR_q[b][j] <= '0;
                    bankI_q[b][j] <= '0;
                end
            end
        end else if (accept) begin
            bankR_q[wrBank_q][wrLane] <= s_r_i;
            bankI_q[wrBank_q][wrLane] <= s_i_i;
        end
    end

endmodule

// File: doc/fft_input_loader.md
# fft_input_loader

Serial-to-parallel input loader for the 32-point DIT FFT datapath. Accepts one complex sample per handshake, writes it in bit-reversed position into a ping-pong frame buffer, and presents a complete 32-lane frame to the first butterfly stage's pipeline register. Double buffering lets the next frame load while the current frame waits for downstream acceptance.

## Interface
- N, 16, width of each real/imaginary component (two's complement)
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- s_valid  in  1  input sample valid
- s_ready  out  1  loader can accept a sample this cycle
- s_r  in  N  sample real part
- s_i  in  N  sample imaginary part
- s_last  in  1  marks the 32nd sample of a frame
- f_valid  out  1  complete frame present on f_r/f_i
- f_ready  in  1  downstream consumes frame this cycle
- f_r  out  32*N  frame real parts; lane j = f_r[(j+1)*N-1 : j*N]
- f_i  out  32*N  frame imaginary parts, same lane packing
- frame_err  out  1  one-cycle pulse on s_last framing mismatch

## Operation
- State: two banks (0/1) of 32 complex words; full[1:0]; wr_bank; rd_bank; 5-bit sample counter cnt.
- Sample accept = s_valid & s_ready. s_ready = !full[wr_bank] (combinational from registered state).
- Accepted sample k (= cnt) is written to lane bitrev5(k) of bank wr_bank; e.g. k=1 -> lane 16, k=3 -> lane 24, k=31 -> lane 31.
- Accept with cnt==31: full[wr_bank] <= 1, wr_bank toggles, cnt <= 0. Otherwise cnt increments.
- s_last rules, evaluated on accepted samples only:
  - s_last=1 and cnt!=31: partial frame discarded (cnt <= 0, bank stays empty, wr_bank unchanged), frame_err pulses.
  - s_last=0 and cnt==31: frame still completes normally, frame_err pulses.
  - s_last=1 and cnt==31: normal completion, no error.
- f_valid = full[rd_bank]. f_r/f_i always drive bank rd_bank contents, whether or not f_valid is high.
- Frame consume = f_valid & f_ready: full[rd_bank] <= 0, rd_bank toggles.
- Both banks full: s_ready=0; input stalls until a frame is consumed.
- Simultaneous completion (bank A) and consume (bank B) in one cycle: both updates apply; no frame lost or duplicated.
- Discarded partial-frame writes leave stale lanes in the write bank; they are overwritten by the next complete frame before it is marked full.
- Data is passed through unmodified: no scaling, rounding or sign handling.

## Timing
- Reset values: all bank words 0, full=00, wr_bank=0, rd_bank=0, cnt=0; hence s_ready=1, f_valid=0, f_r=f_i=0, frame_err=0.
- Reset mid-frame: partial frame and any pending frames are dropped immediately (asynchronous); outputs return to reset values.
- Latency: 32nd sample accepted at edge t -> f_valid=1 and frame on f_r/f_i from edge t until consumed.
- frame_err is registered: asserted for exactly the one cycle following the offending accept edge.
- s_ready deasserts on the edge after the second bank completes; it reasserts on the edge after a consume.
- Throughput: one frame per 32 accepted samples. With f_ready held at 1, s_ready never drops.
- f_ready with f_valid=0 has no effect.

## Test plan
- Reset, then stream samples k=0..31 (s_r=k, s_i=-k, s_last on k=31), f_ready=1 -> f_valid rises after the 32nd accept; lane 0 = (0,0), lane 1 = (16,-16), lane 2 = (8,-8), lane 31 = (31,-31); f_valid high for one cycle.
- f_ready=0, stream three back-to-back frames -> s_ready drops after the 64th accept; frame 1 held stable; then f_ready=1 for one cycle -> frame 2 presented, s_ready returns to 1, frame 3 completes.
- Sustained streaming with f_ready=1 and a frame completing in the same cycle as a consume -> every frame is presented exactly once, in order, and s_ready stays 1.
- s_last asserted on k=9 -> frame_err pulses once, no f_valid; the next 32 samples form a correct frame. A separate case with s_last missing on k=31 -> frame completes and frame_err pulses.
- Assert rst after sample 20 with one full frame pending -> f_valid=0, s_ready=1, all f_r/f_i=0; a fresh 32-sample frame then loads correctly.
